// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: redirect flush, load-use stall and mult/div wait FSM with watchdog.
// Optional perf counters (stall_cnt, flush_cnt) are built when HAZARD_PERF_EN is defined.
module hazard_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        id_mdu,
   input  logic [4:0]  ex_rt,
   input  logic        ex_MemRead,
   input  logic        ex_redirect,
   input  logic        mdu_busy,
   output logic        PCWrite,
   output logic        IFIDWrite,
   output logic        IFIDflush,
   output logic        IDEXflush,
   output logic        mdu_timeout,
   output logic        state_dbg
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   typedef enum logic {
      RUN      = 1'b0,
      MDU_WAIT = 1'b1
   } state_t;

   state_t     state;
   state_t     next_state;
   logic [5:0] wait_cnt;
   logic       load_use;
   logic       mdu_stall;
   logic       wait_busy;

   assign load_use  = ex_MemRead && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   assign mdu_stall = id_mdu && mdu_busy;
   assign wait_busy = (state == MDU_WAIT) && mdu_busy;
   assign state_dbg = state;

   always_comb begin
      next_state = state;
      PCWrite    = 1'b1;
      IFIDWrite  = 1'b1;
      IFIDflush  = 1'b0;
      IDEXflush  = 1'b0;
      if (!rst) begin
         PCWrite    = 1'b0;
         IFIDWrite  = 1'b0;
         IFIDflush  = 1'b1;
         IDEXflush  = 1'b1;
         next_state = RUN;
      end else begin
         case (state)
            RUN: begin
               if (ex_redirect) begin
                  IFIDflush = 1'b1;
                  IDEXflush = 1'b1;
               end else if (load_use || mdu_stall) begin
                  // load-use takes priority for outputs, but a concurrent mdu stall still enters the wait
                  PCWrite   = 1'b0;
                  IFIDWrite = 1'b0;
                  IDEXflush = 1'b1;
                  if (mdu_stall) next_state = MDU_WAIT;
               end
            end
            MDU_WAIT: begin
               if (ex_redirect) begin
                  IFIDflush  = 1'b1;
                  IDEXflush  = 1'b1;
                  next_state = RUN;
               end else if (mdu_busy) begin
                  PCWrite   = 1'b0;
                  IFIDWrite = 1'b0;
                  IDEXflush = 1'b1;
               end else begin
                  next_state = RUN;
               end
            end
            default: next_state = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= RUN;
         wait_cnt    <= 6'd0;
         mdu_timeout <= 1'b0;
      end else begin
         state <= next_state;
         if ((state == RUN) && (next_state == MDU_WAIT))
            wait_cnt <= 6'd0;
         else if (wait_busy && (wait_cnt != 6'd63))
            wait_cnt <= wait_cnt + 6'd1;
         if (wait_busy && (wait_cnt == 6'd63))
            mdu_timeout <= 1'b1;
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt <= 32'd0;
         flush_cnt <= 32'd0;
      end else begin
         if (!PCWrite && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
         if (ex_redirect && (flush_cnt != 32'hFFFF_FFFF))
            flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver pushes model predictions, monitor compares at negedge.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
   localparam int W = 70;
`else
   localparam int W = 6;
`endif

   logic       clk;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_uses_rt, id_mdu, ex_MemRead, ex_redirect, mdu_busy;
   logic       PCWrite, IFIDWrite, IFIDflush, IDEXflush, mdu_timeout, state_dbg;
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   hazard_ctrl dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_mdu(id_mdu),
      .ex_rt(ex_rt), .ex_MemRead(ex_MemRead), .ex_redirect(ex_redirect), .mdu_busy(mdu_busy),
      .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDflush(IFIDflush), .IDEXflush(IDEXflush),
      .mdu_timeout(mdu_timeout), .state_dbg(state_dbg)
`ifdef HAZARD_PERF_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   // scoreboard
   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           checks = 0;
   int           passed = 0;
   string        phase = "reset";

   // reference model: pipeline-level bookkeeping
   bit     m_wait = 0;
   int     m_busy_waits = 0;
   bit     m_timeout = 0;
   longint m_stall = 0;
   longint m_flush = 0;

   function automatic longint sat32(longint v);
      return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
   endfunction

   task automatic drive(input bit r, input bit [4:0] rs, input bit [4:0] rt, input bit uses_rt,
                        input bit mdu, input bit [4:0] xrt, input bit memrd, input bit redir,
                        input bit busy);
      bit [3:0] outs;
      bit       lu;
      logic [W-1:0] e;
      @(posedge clk);
      #1;
      rst = r; id_rs = rs; id_rt = rt; id_uses_rt = uses_rt; id_mdu = mdu;
      ex_rt = xrt; ex_MemRead = memrd; ex_redirect = redir; mdu_busy = busy;
      lu = memrd && (xrt != 0) && ((xrt == rs) || (uses_rt && (xrt == rt)));
      if (!r)
         outs = 4'b0011;
      else if (redir)
         outs = 4'b1111;
      else if ((!m_wait && (lu || (mdu && busy))) || (m_wait && busy))
         outs = 4'b0001;
      else
         outs = 4'b1100;
`ifdef HAZARD_PERF_EN
      e = {outs, m_timeout, m_wait, 32'(m_stall), 32'(m_flush)};
`else
      e = {outs, m_timeout, m_wait};
`endif
      exp_q.push_back(e);
      name_q.push_back(phase);
      // state update for the coming clock edge
      if (!r) begin
         m_wait = 0; m_busy_waits = 0; m_timeout = 0; m_stall = 0; m_flush = 0;
      end else begin
         if (outs[3] == 1'b0) m_stall = sat32(m_stall + 1);
         if (redir) m_flush = sat32(m_flush + 1);
         if (m_wait) begin
            if (busy) begin
               if (m_busy_waits >= 63) m_timeout = 1;
               m_busy_waits++;
            end
            m_wait = !redir && busy;
         end else begin
            m_wait = !redir && mdu && busy;
            if (m_wait) m_busy_waits = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1, 1, 2, 1, 0, 3, 0, 0, 0);
   endtask

   // monitor: outputs are presented every cycle, sampled mid-cycle
   always @(negedge clk) begin
      logic [W-1:0] got;
      logic [W-1:0] e;
      string        n;
      if (exp_q.size() != 0) begin
`ifdef HAZARD_PERF_EN
         got = {PCWrite, IFIDWrite, IFIDflush, IDEXflush, mdu_timeout, state_dbg, stall_cnt, flush_cnt};
`else
         got = {PCWrite, IFIDWrite, IFIDflush, IDEXflush, mdu_timeout, state_dbg};
`endif
         e = exp_q.pop_front();
         n = name_q.pop_front();
         checks++;
         if (got === e) passed++;
         else $display("FAIL %s: got=%h expected=%h at %0t", n, got, e, $time);
      end
   end

   initial begin
      rst = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_mdu = 0;
      ex_rt = 0; ex_MemRead = 0; ex_redirect = 0; mdu_busy = 0;

      phase = "reset";
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 5, 5, 1, 1, 5, 1, 0, 1);
      phase = "idle";
      idle(2);

      phase = "load_use";
      drive(1, 5, 9, 0, 0, 5, 1, 0, 0);
      drive(1, 5, 9, 0, 0, 0, 0, 0, 0);
      drive(1, 9, 5, 1, 0, 5, 1, 0, 0);
      drive(1, 9, 5, 1, 0, 5, 0, 0, 0);

      phase = "no_stall_r0";
      drive(1, 0, 0, 1, 0, 0, 1, 0, 0);
      phase = "no_stall_rt_unused";
      drive(1, 3, 7, 0, 0, 7, 1, 0, 0);

      phase = "redirect_over_load_use";
      drive(1, 5, 5, 1, 0, 5, 1, 1, 0);
      idle(1);

      phase = "mdu_4cycles";
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(1, 1, 2, 0, 1, 3, 0, 0, 1);
      drive(1, 1, 2, 0, 1, 3, 0, 0, 0);
      idle(2);

      phase = "mdu_lu_together";
      drive(1, 4, 2, 0, 1, 4, 1, 0, 1);
      drive(1, 4, 2, 0, 1, 4, 0, 0, 1);
      phase = "redirect_in_wait";
      drive(1, 4, 2, 0, 1, 4, 0, 1, 1);
      idle(1);

      phase = "mdu_timeout";
      for (int i = 0; i < 70; i++) drive(1, 1, 2, 0, 1, 3, 0, 0, 1);
      drive(1, 1, 2, 0, 1, 3, 0, 0, 0);
      idle(3);
      phase = "timeout_cleared_by_reset";
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);

      phase = "reset_mid_wait";
      for (int i = 0; i < 3; i++) drive(1, 1, 2, 0, 1, 3, 0, 0, 1);
      drive(0, 1, 2, 0, 1, 3, 0, 0, 1);
      drive(1, 1, 2, 0, 0, 3, 0, 0, 1);
      idle(1);

      phase = "random";
      for (int i = 0; i < 500; i++) begin
         drive(($urandom_range(0, 59) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 4) != 0));
      end

      @(posedge clk);
      @(posedge clk);
      checks++;
      if (exp_q.size() == 0) passed++;
      else $display("FAIL drain: got=%0d pending expected=0", exp_q.size());

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on posedge clk.
REQ-002 SHALL: rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL: id_rs, id_rt  in  5 each  source registers of the instruction in ID.
REQ-004 SHALL: id_uses_rt  in  1  ID instruction reads rt as a source.
REQ-005 SHALL: id_mdu  in  1  ID instruction is a mult/div.
REQ-006 SHALL: ex_rt  in  5  rt of the instruction in EX, taken from the ID/EX register.
REQ-007 SHALL: ex_MemRead  in  1  EX instruction is a load.
REQ-008 SHALL: ex_redirect  in  1  branch taken or jump resolved in EX.
REQ-009 SHALL: mdu_busy  in  1  mult/div unit is occupied.
REQ-010 SHALL: PCWrite, IFIDWrite  out  1 each  enables for the PC and IF/ID registers.
REQ-011 SHALL: IFIDflush, IDEXflush  out  1 each  bubble insertion into IF/ID and ID/EX.
REQ-012 SHALL: mdu_timeout  out  1  sticky watchdog error flag.

Function
REQ-013 SHALL: implement a two-state FSM: RUN and MDU_WAIT.
REQ-014 SHALL: drive outputs combinationally from the current state and the inputs; state, counters and flags are registered.
REQ-015 SHALL: in RUN, apply this priority order: redirect, then load-use, then mdu-stall, then normal.
REQ-016 SHALL: on redirect (ex_redirect=1), drive IFIDflush=1, IDEXflush=1, PCWrite=1, IFIDWrite=1; the FSM stays in RUN.
REQ-017 SHALL: detect load-use when ex_MemRead=1, ex_rt!=0 and (ex_rt==id_rs, or id_uses_rt=1 and ex_rt==id_rt).
REQ-018 SHALL: on load-use, drive PCWrite=0, IFIDWrite=0, IDEXflush=1, IFIDflush=0 for exactly one cycle; the FSM stays in RUN, and the EX bubble clears the condition on the next cycle.
REQ-019 SHALL: on mdu-stall (id_mdu=1 and mdu_busy=1), apply the same outputs as load-use and move RUN->MDU_WAIT.
REQ-020 SHALL: in the normal case, drive PCWrite=1, IFIDWrite=1, both flushes=0.
REQ-021 SHALL: in MDU_WAIT while mdu_busy=1, drive PCWrite=0, IFIDWrite=0, IDEXflush=1, IFIDflush=0.
REQ-022 SHALL: in MDU_WAIT when mdu_busy=0, drive normal outputs that same cycle and move to RUN.
REQ-023 SHALL: treat ex_redirect=1 in MDU_WAIT as in REQ-016 and move to RUN; redirect overrides the stall.
REQ-024 SHALL: keep a 6-bit wait counter that clears on entering MDU_WAIT and increments each MDU_WAIT cycle with mdu_busy=1, saturating at 63.
REQ-025 SHALL: set mdu_timeout to 1 when the wait counter reaches 63 while still busy; it holds until reset.
REQ-026 SHALL: on load-use and mdu-stall asserted together, take the load-use outputs and also enter MDU_WAIT.

Reset
REQ-027 SHALL: while rst=0 at posedge clk, set state=RUN, wait counter=0, mdu_timeout=0, and clear the perf counters (when present).
REQ-028 SHALL: while rst=0, force PCWrite=0, IFIDWrite=0, IFIDflush=1, IDEXflush=1.
REQ-029 SHALL: on reset during MDU_WAIT, abandon the wait; the first cycle after reset release is RUN with normal outputs if no hazard is present.

Configuration
REQ-030 SHALL: with macro HAZARD_PERF_EN defined, add outputs stall_cnt[31:0] (cycles with PCWrite=0 outside reset) and flush_cnt[31:0] (redirect cycles).
REQ-031 SHALL: make both perf counters saturate at 32'hFFFFFFFF and reset to 0.
REQ-032 SHALL: with HAZARD_PERF_EN undefined, omit those ports and logic entirely; all other behaviour is unchanged.

Verification
REQ-033 SHALL: cover ex_MemRead=1, ex_rt=5, id_rs=5 -> one cycle with PCWrite=0, IFIDWrite=0, IDEXflush=1, then normal once ex_MemRead=0.
REQ-034 SHALL: cover ex_MemRead=1, ex_rt=0, id_rs=0 -> no stall; also ex_rt=7, id_rt=7, id_uses_rt=0 -> no stall.
REQ-035 SHALL: cover ex_redirect=1 together with a load-use match -> IFIDflush=1, IDEXflush=1, PCWrite=1.
REQ-036 SHALL: cover id_mdu=1 with mdu_busy=1 for 4 cycles then 0 -> 4 stall cycles, normal in cycle 5, state RUN; stall_cnt=4 when HAZARD_PERF_EN is defined.
REQ-037 SHALL: cover mdu_busy held at 1 for 70 cycles in MDU_WAIT -> mdu_timeout=1, remaining 1 until rst=0 is applied for one posedge.
REQ-038 SHALL: cover rst=0 asserted mid-MDU_WAIT -> reset outputs per REQ-028, then RUN after release.
